// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding and frame constants
package uart_pkg;
   localparam int UART_DATA_BITS = 8;
   typedef enum logic [2:0] {
      UART_RX_IDLE  = 3'd0,
      UART_RX_START = 3'd1,
      UART_RX_DATA  = 3'd2,
      UART_RX_STOP  = 3'd3,
      UART_RX_BREAK = 3'd4
   } uart_rx_state_e;
endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: 1-bit two-flop synchroniser for asynchronous idle-high inputs
module uart_sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic s1_q, s2_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   assign q_o = s2_q;
endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: 8N1 UART receiver with majority-vote sampling and a held output byte
module uart_rx_controller
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_Rx_Serial,
   input  logic                      i_Rx_Read,
   output logic [UART_DATA_BITS-1:0] o_Rx_Byte,
   output logic                      o_Rx_Valid,
   output logic                      o_Rx_Active,
   output logic                      o_Rx_Frame_Err,
   output logic                      o_Rx_Overrun
);
   localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] SMP0    = CNT_W'(CLKS_PER_BIT - 3);
   localparam logic [CNT_W-1:0] SMP1    = CNT_W'(CLKS_PER_BIT - 2);

   uart_rx_state_e              state_q;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [2:0]                  bit_idx_q;
   logic [UART_DATA_BITS-1:0]   shift_q, byte_q;
   logic [1:0]                  smp_q;
   logic                        active_q, ferr_q, valid_q, ovr_q;
   logic                        rx_s, in_bit, bit_tc, maj, load;

   uart_sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (i_Rx_Serial),
      .q_o   (rx_s)
   );

   assign in_bit = state_q == UART_RX_DATA || state_q == UART_RX_STOP;
   assign bit_tc = in_bit && cnt_q == BIT_TC;
   // third vote is the live line value on the terminal count cycle
   assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
   assign load   = state_q == UART_RX_STOP && bit_tc && maj;

   always_comb
      cnt_d = state_q == UART_RX_START ? (cnt_q == HALF_TC ? '0 : cnt_q + 1'b1)
            : in_bit ? (bit_tc ? '0 : cnt_q + 1'b1) : '0;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q  <= UART_RX_IDLE;
         active_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         case (state_q)
            UART_RX_IDLE:
               if (!rx_s) begin
                  state_q  <= UART_RX_START;
                  active_q <= 1'b1;
               end
            UART_RX_START:
               if (cnt_q == HALF_TC) begin
                  state_q  <= rx_s ? UART_RX_IDLE : UART_RX_DATA;
                  active_q <= ~rx_s;
               end
            UART_RX_DATA:
               if (bit_tc && bit_idx_q == 3'd7) state_q <= UART_RX_STOP;
            UART_RX_STOP:
               if (bit_tc) begin
                  state_q  <= maj ? UART_RX_IDLE : UART_RX_BREAK;
                  active_q <= ~maj;
                  ferr_q   <= ~maj;
               end
            UART_RX_BREAK:
               if (rx_s) begin
                  state_q  <= UART_RX_IDLE;
                  active_q <= 1'b0;
               end
            default: begin
               state_q  <= UART_RX_IDLE;
               active_q <= 1'b0;
            end
         endcase
      end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         smp_q     <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (in_bit && cnt_q == SMP0) smp_q[0] <= rx_s;
         if (in_bit && cnt_q == SMP1) smp_q[1] <= rx_s;
         if (state_q == UART_RX_DATA && bit_tc) begin
            shift_q[bit_idx_q] <= maj;
            bit_idx_q          <= bit_idx_q + 1'b1;
         end
      end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         byte_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= load && valid_q && !i_Rx_Read;
         if (load && (!valid_q || i_Rx_Read)) begin
            byte_q  <= shift_q;
            valid_q <= 1'b1;
         end else if (valid_q && i_Rx_Read) valid_q <= 1'b0;
      end

   assign o_Rx_Byte      = byte_q;
   assign o_Rx_Valid     = valid_q;
   assign o_Rx_Active    = active_q;
   assign o_Rx_Frame_Err = ferr_q;
   assign o_Rx_Overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed frame table plus hand sequences for the receiver corner cases
module tb_uart_rx_controller;
   localparam int CPB = 16;
   localparam int LAT = CPB / 2 + 9 * CPB + 1 + 2;

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic [7:0] gl;
      logic [7:0] exp_byte;
      logic       exp_valid;
      int         exp_ferr;
   } vec_t;

   logic       clk = 1'b0, reset = 1'b0, rx = 1'b1, rd = 1'b0;
   logic [7:0] byte_o;
   logic       valid, active, ferr, ovr;
   logic       prev_valid = 1'b0;
   int         n_vec = 0, n_bad = 0;
   int         cyc = 0, rise_cyc = -1, ferr_n = 0, ovr_n = 0, ovr_cyc = -1, start_cyc = 0;
   vec_t       tbl[7];

   uart_rx_controller #(.CLKS_PER_BIT(CPB), .CNT_W(10)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_Rx_Serial    (rx),
      .i_Rx_Read      (rd),
      .o_Rx_Byte      (byte_o),
      .o_Rx_Valid     (valid),
      .o_Rx_Active    (active),
      .o_Rx_Frame_Err (ferr),
      .o_Rx_Overrun   (ovr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid && !prev_valid) rise_cyc = cyc;
      prev_valid = valid;
      if (ferr) ferr_n++;
      if (ovr) begin
         ovr_n++;
         ovr_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // gl[k] injects a 1-clk inverted pulse inside the vote window of data bit k
   task automatic send(input logic [7:0] d, input logic stop, input logic [7:0] gl);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      start_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         if (i >= 1 && i <= 8 && gl[i-1]) begin
            hold(6 + i % 3);
            rx = ~bits[i];
            hold(1);
            rx = bits[i];
            hold(CPB - 7 - i % 3);
         end else hold(CPB);
      end
   endtask

   task automatic read_pulse();
      rd = 1'b1;
      hold(1);
      rd = 1'b0;
   endtask

   initial begin
      int f0, o0;
      tbl[0] = '{8'hA5, 1'b1, 8'h00, 8'hA5, 1'b1, 0};
      tbl[1] = '{8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 0};
      tbl[2] = '{8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 0};
      tbl[3] = '{8'h5A, 1'b1, 8'h5A, 8'h5A, 1'b1, 0};
      tbl[4] = '{8'h3C, 1'b0, 8'h00, 8'h5A, 1'b0, 1};
      tbl[5] = '{8'h81, 1'b1, 8'h00, 8'h81, 1'b1, 0};
      tbl[6] = '{8'h01, 1'b1, 8'h81, 8'h01, 1'b1, 0};

      reset = 1'b1;
      hold(3);
      check("rst_byte", byte_o, 8'h00);
      check("rst_valid", valid, 0);
      check("rst_active", active, 0);
      check("rst_ferr", ferr, 0);
      check("rst_ovr", ovr, 0);
      reset = 1'b0;
      hold(3);

      for (int v = 0; v < 7; v++) begin
         read_pulse();
         check($sformatf("v%0d_rd_clear", v), valid, 0);
         f0 = ferr_n;
         o0 = ovr_n;
         send(tbl[v].d, tbl[v].stop, tbl[v].gl);
         rx = 1'b1;
         hold(20);
         check($sformatf("v%0d_byte", v), byte_o, tbl[v].exp_byte);
         check($sformatf("v%0d_valid", v), valid, tbl[v].exp_valid);
         check($sformatf("v%0d_ferr", v), ferr_n - f0, tbl[v].exp_ferr);
         check($sformatf("v%0d_ovr", v), ovr_n - o0, 0);
         check($sformatf("v%0d_active", v), active, 0);
         if (tbl[v].exp_valid) check($sformatf("v%0d_latency", v), rise_cyc - start_cyc, LAT);
      end

      read_pulse();
      f0 = ferr_n;
      o0 = ovr_n;
      rx = 1'b0;
      hold(5);
      check("glitch_active_start", active, 1);
      rx = 1'b1;
      hold(30);
      check("glitch_active", active, 0);
      check("glitch_valid", valid, 0);
      check("glitch_ferr", ferr_n - f0, 0);
      check("glitch_ovr", ovr_n - o0, 0);

      f0 = ferr_n;
      send(8'h3C, 1'b0, 8'h00);
      hold(40);
      check("break_active", active, 1);
      check("break_ferr", ferr_n - f0, 1);
      check("break_valid", valid, 0);
      rx = 1'b1;
      hold(5);
      check("break_exit_active", active, 0);
      send(8'h81, 1'b1, 8'h00);
      hold(10);
      check("after_break_byte", byte_o, 8'h81);
      check("after_break_valid", valid, 1);
      check("after_break_latency", rise_cyc - start_cyc, LAT);

      read_pulse();
      o0 = ovr_n;
      send(8'h11, 1'b1, 8'h00);
      send(8'h22, 1'b1, 8'h00);
      hold(10);
      check("ovr_byte", byte_o, 8'h11);
      check("ovr_valid", valid, 1);
      check("ovr_count", ovr_n - o0, 1);
      check("ovr_timing", ovr_cyc - start_cyc, LAT);
      read_pulse();
      check("ovr_read_valid", valid, 0);
      check("ovr_read_byte", byte_o, 8'h11);

      send(8'hAA, 1'b1, 8'h00);
      hold(10);
      check("pend_byte", byte_o, 8'hAA);
      check("pend_valid", valid, 1);
      o0 = ovr_n;
      fork
         send(8'h55, 1'b1, 8'h00);
         begin
            hold(LAT - 1);
            rd = 1'b1;
            hold(1);
            rd = 1'b0;
         end
      join
      hold(5);
      check("rdload_byte", byte_o, 8'h55);
      check("rdload_valid", valid, 1);
      check("rdload_ovr", ovr_n - o0, 0);

      fork
         send(8'hF0, 1'b1, 8'h00);
         begin
            hold(CPB * 5 + 8);
            check("pre_rst_active", active, 1);
            @(negedge clk);
            reset = 1'b1;
            #1;
            check("midrst_byte", byte_o, 8'h00);
            check("midrst_valid", valid, 0);
            check("midrst_active", active, 0);
            check("midrst_ferr", ferr, 0);
            check("midrst_ovr", ovr, 0);
         end
      join
      hold(2);
      reset = 1'b0;
      hold(5);
      check("post_rst_active", active, 0);
      f0 = ferr_n;
      send(8'h0F, 1'b1, 8'hA5);
      hold(10);
      check("post_rst_byte", byte_o, 8'h0F);
      check("post_rst_valid", valid, 1);
      check("post_rst_latency", rise_cyc - start_cyc, LAT);
      check("post_rst_ferr", ferr_n - f0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
